// File: rtl/config_pkg.sv
// Core configuration types and register-file constants shared by the regfile slice.
package config_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } config_t;

  localparam config_t DEFAULT_CONF = '{XLEN: 32};

  localparam int REGFILE_NUM_REGS = 32;
  localparam int REGFILE_NUM_RD   = 2;
  localparam int REGFILE_AW       = $clog2(REGFILE_NUM_REGS);

  typedef logic [REGFILE_AW-1:0] reg_addr_t;

  typedef struct packed {
    logic                        en;
    reg_addr_t                   addr;
    logic [DEFAULT_CONF.XLEN-1:0] data;
  } regfile_wr_t;

endpackage

// File: rtl/core_regfile_scoreboard.sv
// Busy scoreboard: tracks registers with a pending long-latency writeback.
module core_regfile_scoreboard
  import config_pkg::*;
#(
  parameter int NUM_REGS = REGFILE_NUM_REGS,
  parameter int NUM_WR   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic                         rsv_ok,
  output logic [NUM_REGS-1:0]          busy_vec
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  assign busy_vec = busy_q;
  assign rsv_ok   = rst_n & (~busy_q[rsv_addr] | (rsv_addr == '0));

  // Releases are applied first so a same-cycle reservation leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) busy_d[wr_addr[w]] = 1'b0;
    end
    if (rsv_en && rsv_ok) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!busy_q[0])
        else $error("scoreboard: busy bit set on register 0");
      assert (!(rsv_en && busy_q[rsv_addr] && (rsv_addr != '0) && rsv_ok))
        else $error("scoreboard: reservation accepted on a busy register");
    end
  end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-ported integer register file with optional write-to-read bypass and busy scoreboard.
module core_regfile_mp
  import config_pkg::*;
#(
  parameter config_t CONF     = DEFAULT_CONF,
  parameter int      NUM_REGS = REGFILE_NUM_REGS,
  parameter int      NUM_RD   = REGFILE_NUM_RD,
  parameter int      NUM_WR   = 1,
  parameter int      BYPASS   = 1,
  localparam int     AW       = $clog2(NUM_REGS),
  localparam int     XLEN     = CONF.XLEN
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD-1:0][AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic                         rsv_ok,
  output logic [NUM_REGS-1:0]          busy_vec
);

  // Same shape as config_pkg::regfile_wr_t, sized to this instance's XLEN/AW.
  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_port_t;

  wr_port_t [NUM_WR-1:0] wr_port;
  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic [XLEN-1:0] mem_d [NUM_REGS];

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      wr_port[w].en   = wr_en[w];
      wr_port[w].addr = wr_addr[w];
      wr_port[w].data = wr_data[w];
    end
  end

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_comb begin
    mem_d = mem_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_port[w].en && (wr_port[w].addr != '0)) begin
        mem_d[wr_port[w].addr] = wr_port[w].data;
      end
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data[r] = '0;
      rd_busy[r] = 1'b0;
      if (rst_n && (rd_addr[r] != '0)) begin
        rd_data[r] = mem_q[rd_addr[r]];
        rd_busy[r] = busy_vec[rd_addr[r]];
        if (BYPASS != 0) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_port[w].en && (wr_port[w].addr == rd_addr[r])) begin
              rd_data[r] = wr_port[w].data;
              rd_busy[r] = 1'b0;
            end
          end
        end
      end
    end
  end

  core_regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .busy_vec (busy_vec)
  );

endmodule

// File: tb/tb_core_regfile_mp.sv
// Directed bench driving a bypassing and a non-bypassing dual-write instance with shared stimulus.
module tb_core_regfile_mp;
  import config_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic [1:0][4:0]      rd_addr;
  logic [1:0][31:0]     rd_data_b, rd_data_n;
  logic [1:0]           rd_busy_b, rd_busy_n;
  logic [1:0]           wr_en;
  logic [1:0][4:0]      wr_addr;
  logic [1:0][31:0]     wr_data;
  logic                 rsv_en;
  logic [4:0]           rsv_addr;
  logic                 rsv_ok_b, rsv_ok_n;
  logic [31:0]          busy_vec_b, busy_vec_n;

  int tests_run = 0;
  int tests_failed = 0;

  core_regfile_mp #(.NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_b), .busy_vec(busy_vec_b)
  );

  core_regfile_mp #(.NUM_REGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) u_dut_nob (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .rsv_ok(rsv_ok_n), .busy_vec(busy_vec_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
      else begin
        tests_failed++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 2'b00;
    rsv_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr  = '0;
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;

    // Reset: outputs forced low, writes and reservations discarded.
    rd_addr[0] = 5'd5;
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h1111_1111;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    check("rst_rsv_ok_b", rsv_ok_b, 1'b0);
    check("rst_rsv_ok_n", rsv_ok_n, 1'b0);
    check("rst_rd_data_b", rd_data_b[0], 32'h0);
    tick();
    tick();
    check("rst_busy_b", busy_vec_b, 32'h0);
    check("rst_busy_n", busy_vec_n, 32'h0);
    idle();
    rst_n = 1'b1;
    #1;
    check("rst_drop_wr", rd_data_n[0], 32'h0);

    // Write x5, then reset clears it.
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    tick();
    idle();
    check("x5_written", rd_data_n[0], 32'hDEAD_BEEF);
    rst_n = 1'b0;
    #1;
    check("x5_in_reset", rd_data_b[0], 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    check("x5_after_rst", rd_data_n[0], 32'h0);
    check("busy_after_rst", busy_vec_n, 32'h0);

    // Register 0 ignores writes on every port and never goes busy.
    rd_addr[0] = 5'd0;
    wr_en = 2'b11; wr_addr[0] = 5'd0; wr_addr[1] = 5'd0;
    wr_data[0] = 32'h1234_5678; wr_data[1] = 32'h1234_5678;
    #1;
    check("x0_byp_read", rd_data_b[0], 32'h0);
    tick();
    idle();
    check("x0_read_b", rd_data_b[0], 32'h0);
    check("x0_read_n", rd_data_n[0], 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("x0_rsv_ok", rsv_ok_b, 1'b1);
    tick();
    idle();
    check("x0_busy", busy_vec_b, 32'h0);
    check("x0_rd_busy", rd_busy_n[0], 1'b0);

    // Same-cycle write/read of x7.
    rd_addr[0] = 5'd7;
    wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'hA5A5_A5A5;
    #1;
    check("byp_x7_same", rd_data_b[0], 32'hA5A5_A5A5);
    check("nob_x7_same", rd_data_n[0], 32'h0);
    tick();
    idle();
    check("byp_x7_next", rd_data_b[0], 32'hA5A5_A5A5);
    check("nob_x7_next", rd_data_n[0], 32'hA5A5_A5A5);

    // Dual-write conflict on x3: port 1 wins.
    rd_addr[1] = 5'd3;
    wr_en = 2'b11; wr_addr[0] = 5'd3; wr_addr[1] = 5'd3;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    #1;
    check("conf_byp", rd_data_b[1], 32'h2);
    check("conf_nob_old", rd_data_n[1], 32'h0);
    tick();
    idle();
    check("conf_arr_b", rd_data_b[1], 32'h2);
    check("conf_arr_n", rd_data_n[1], 32'h2);

    // Scoreboard reserve / duplicate reserve / release on x9.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    check("x9_rsv_ok", rsv_ok_n, 1'b1);
    tick();
    idle();
    rd_addr[0] = 5'd9;
    #1;
    check("x9_busy_vec", busy_vec_n, 32'h0000_0200);
    check("x9_rd_busy_n", rd_busy_n[0], 1'b1);
    check("x9_rd_busy_b", rd_busy_b[0], 1'b1);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    check("x9_rsv_again", rsv_ok_b, 1'b0);
    tick();
    idle();
    check("x9_still_busy", busy_vec_b, 32'h0000_0200);
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h55;
    #1;
    check("x9_wb_busy_b", rd_busy_b[0], 1'b0);
    check("x9_wb_data_b", rd_data_b[0], 32'h55);
    check("x9_wb_busy_n", rd_busy_n[0], 1'b1);
    tick();
    idle();
    check("x9_released", busy_vec_n, 32'h0);
    check("x9_data_n", rd_data_n[0], 32'h55);
    check("x9_rd_busy_after", rd_busy_n[0], 1'b0);

    // Write and reserve x4 in one cycle: data lands, bit ends set.
    rd_addr[1] = 5'd4;
    wr_en = 2'b10; wr_addr[1] = 5'd4; wr_data[1] = 32'hCAFE_0004;
    rsv_en = 1'b1; rsv_addr = 5'd4;
    #1;
    check("x4_rsv_ok", rsv_ok_n, 1'b1);
    tick();
    idle();
    check("x4_data", rd_data_n[1], 32'hCAFE_0004);
    check("x4_busy_vec", busy_vec_b, 32'h0000_0010);
    check("x4_rd_busy", rd_busy_n[1], 1'b1);

    // Reset drops the reservation; a late writeback leaves the bit clear.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rst_busy", busy_vec_n, 32'h0);
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h77;
    tick();
    idle();
    check("late_wb_busy", busy_vec_b, 32'h0);
    check("late_wb_data", rd_data_n[1], 32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
